// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Default timing is 640x480 @ 60 Hz from a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COORD_W = 10;

    // True when value lies in [lo, lo+len-1].
    function automatic logic in_window(input logic [COORD_W-1:0] value,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(value) >= lo) && (32'(value) < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered active-low sync.
// active is a combinational "next position is visible" flag for the parent to register.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL    = H_TOTAL,
    parameter int unsigned SYNC_LO  = H_VISIBLE + H_FP,
    parameter int unsigned SYNC_LEN = H_SYNC,
    parameter int unsigned VISIBLE  = H_VISIBLE
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               inc,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               sync_n,
    output logic               active
);

    logic [COORD_W-1:0] count_d;
    logic               at_end;

    assign at_end = (count == COORD_W'(TOTAL - 1));
    assign wrap   = inc && at_end;

    always_comb begin
        count_d = count;
        if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count + COORD_W'(1);
        end
    end

    // Decoded from the next position so the sync flop lines up with the count flop.
    assign active = (32'(count_d) < VISIBLE);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            count  <= '0;
            sync_n <= 1'b1;
        end else begin
            count  <= count_d;
            sync_n <= !in_window(count_d, SYNC_LO, SYNC_LEN);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: DrawX/DrawY, active-low hs/vs, blank and frame markers.
// Define VGA_FRAME_CNT_EN to build the frame_count register; otherwise it is tied to 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic               vga_clk,
    input  logic               reset,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;

    vga_axis_counter #(
        .TOTAL    (H_TOT),
        .SYNC_LO  (H_VISIBLE + H_FP),
        .SYNC_LEN (H_SYNC),
        .VISIBLE  (H_VISIBLE)
    ) u_h_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .inc     (1'b1),
        .count   (DrawX),
        .wrap    (h_wrap),
        .sync_n  (hs),
        .active  (h_active)
    );

    vga_axis_counter #(
        .TOTAL    (V_TOT),
        .SYNC_LO  (V_VISIBLE + V_FP),
        .SYNC_LEN (V_SYNC),
        .VISIBLE  (V_VISIBLE)
    ) u_v_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .inc     (h_wrap),
        .count   (DrawY),
        .wrap    (v_wrap),
        .sync_n  (vs),
        .active  (v_active)
    );

    // v_wrap is the only way (0,0) is loaded outside reset, so it marks the frame start.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            blank       <= h_active && v_active;
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (v_wrap) begin
            frame_count <= frame_count + FRAME_W'(1);
        end
    end
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus a shrunken-timing instance,
// both checked every cycle against a behavioural model through expected-value queues.
module tb_vga_timing_gen;

    // Shrunken raster so whole frames fit in a short run: 25 x 19 = 475 cycles per frame.
    localparam int unsigned S_HV  = 16;
    localparam int unsigned S_HFP = 2;
    localparam int unsigned S_HS  = 4;
    localparam int unsigned S_HBP = 3;
    localparam int unsigned S_VV  = 12;
    localparam int unsigned S_VFP = 2;
    localparam int unsigned S_VS  = 2;
    localparam int unsigned S_VBP = 3;
    localparam int unsigned S_FW  = 2;
    localparam int unsigned S_FRAME = 475;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_hs, d_vs, d_blank, d_fs;
    logic       s_hs, s_vs, s_blank, s_fs;
    logic [7:0] d_fc;
    logic [1:0] s_fc;

    obs_t obs_def, obs_small;
    obs_t m_def, m_small;
    obs_t exp_d, exp_s;
    obs_t q_def[$];
    obs_t q_small[$];

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_dut_def (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (d_x),
        .DrawY       (d_y),
        .hs          (d_hs),
        .vs          (d_vs),
        .blank       (d_blank),
        .frame_start (d_fs),
        .frame_count (d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV),
        .H_FP      (S_HFP),
        .H_SYNC    (S_HS),
        .H_BP      (S_HBP),
        .V_VISIBLE (S_VV),
        .V_FP      (S_VFP),
        .V_SYNC    (S_VS),
        .V_BP      (S_VBP),
        .FRAME_W   (S_FW)
    ) u_dut_small (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank       (s_blank),
        .frame_start (s_fs),
        .frame_count (s_fc)
    );

    assign obs_def   = {d_x, d_y, d_hs, d_vs, d_blank, d_fs, d_fc};
    assign obs_small = {s_x, s_y, s_hs, s_vs, s_blank, s_fs, 6'd0, s_fc};

    function automatic obs_t model_next(input obs_t cur, input logic rst,
                                        input int unsigned hv, input int unsigned hfp,
                                        input int unsigned hsw, input int unsigned hbp,
                                        input int unsigned vv, input int unsigned vfp,
                                        input int unsigned vsw, input int unsigned vbp,
                                        input int unsigned fw);
        obs_t        n;
        int unsigned ht;
        int unsigned vt;
        int unsigned nx;
        int unsigned ny;
        logic        line_end;
        logic        wrap;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        n = '0;
        if (rst) begin
            n.hs = 1'b1;
            n.vs = 1'b1;
            return n;
        end
        line_end = (32'(cur.x) == ht - 1);
        wrap     = line_end && (32'(cur.y) == vt - 1);
        nx = line_end ? 0 : 32'(cur.x) + 1;
        ny = !line_end ? 32'(cur.y) : (wrap ? 0 : 32'(cur.y) + 1);
        n.x     = 10'(nx);
        n.y     = 10'(ny);
        n.hs    = !((nx >= hv + hfp) && (nx < hv + hfp + hsw));
        n.vs    = !((ny >= vv + vfp) && (ny < vv + vfp + vsw));
        n.blank = (nx < hv) && (ny < vv);
        n.fs    = (nx == 0) && (ny == 0);
`ifdef VGA_FRAME_CNT_EN
        n.fc = wrap ? 8'((32'(cur.fc) + 1) % (32'd1 << fw)) : cur.fc;
`else
        n.fc = 8'd0;
        if (fw == 0) n.fc = 8'd0;
`endif
        return n;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d",
                         o.x, o.y, o.hs, o.vs, o.blank, o.fs, o.fc);
    endfunction

    // Drives one cycle of stimulus and queues what each DUT should show after the edge.
    task automatic tick(input logic rst);
        reset   = rst;
        m_def   = model_next(m_def, rst, 640, 16, 96, 48, 480, 10, 2, 33, 8);
        m_small = model_next(m_small, rst, S_HV, S_HFP, S_HS, S_HBP,
                             S_VV, S_VFP, S_VS, S_VBP, S_FW);
        q_def.push_back(m_def);
        q_small.push_back(m_small);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t rst_val;
        rst_val = '0;
        rst_val.hs = 1'b1;
        rst_val.vs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            exp_d = q_def.pop_front();
            exp_s = q_small.pop_front();
            checks += 2;
            if (obs_def !== exp_d) begin
                errors++;
                $display("FAIL reset_def got %s want %s", fmt(obs_def), fmt(exp_d));
            end
            if (obs_small !== exp_s) begin
                errors++;
                $display("FAIL reset_small got %s want %s", fmt(obs_small), fmt(exp_s));
            end
        end
        checks++;
        if (obs_def !== rst_val) begin
            errors++;
            $display("FAIL reset_values got %s want %s", fmt(obs_def), fmt(rst_val));
        end
        tick(1'b0);
        exp_d = q_def.pop_front();
        exp_s = q_small.pop_front();
        checks += 3;
        if (obs_def !== exp_d) begin
            errors++;
            $display("FAIL release_def got %s want %s", fmt(obs_def), fmt(exp_d));
        end
        if (obs_small !== exp_s) begin
            errors++;
            $display("FAIL release_small got %s want %s", fmt(obs_small), fmt(exp_s));
        end
        if (d_x !== 10'd1 || d_y !== 10'd0 || d_blank !== 1'b1) begin
            errors++;
            $display("FAIL release_first_pixel got x=%0d y=%0d blank=%b want x=1 y=0 blank=1",
                     d_x, d_y, d_blank);
        end
    endtask

    // Default timing, from (1,0) to the start of line 1.
    task automatic test_line();
        int   blank_fall;
        int   hs_first;
        int   hs_last;
        int   hs_cnt;
        int   prev_x;
        logic wrapped;
        blank_fall = -1;
        hs_first   = -1;
        hs_last    = -1;
        hs_cnt     = 0;
        prev_x     = -1;
        wrapped    = 1'b0;
        for (int i = 0; i < 900 && !wrapped; i++) begin
            prev_x = int'(d_x);
            tick(1'b0);
            exp_d = q_def.pop_front();
            exp_s = q_small.pop_front();
            checks += 2;
            if (obs_def !== exp_d) begin
                errors++;
                $display("FAIL line_def got %s want %s", fmt(obs_def), fmt(exp_d));
            end
            if (obs_small !== exp_s) begin
                errors++;
                $display("FAIL line_small got %s want %s", fmt(obs_small), fmt(exp_s));
            end
            if (d_blank === 1'b0 && blank_fall < 0 && d_y === 10'd0) blank_fall = int'(d_x);
            if (d_hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            if (d_x === 10'd0) wrapped = 1'b1;
        end
        checks += 6;
        if (!wrapped) begin
            errors++;
            $display("FAIL line_timeout got no wrap in 900 cycles want wrap after 799");
        end
        if (blank_fall != 640) begin
            errors++;
            $display("FAIL line_blank_fall got x=%0d want x=640", blank_fall);
        end
        if (hs_first != 656 || hs_last != 751) begin
            errors++;
            $display("FAIL line_hs_window got %0d..%0d want 656..751", hs_first, hs_last);
        end
        if (hs_cnt != 96) begin
            errors++;
            $display("FAIL line_hs_width got %0d want 96", hs_cnt);
        end
        if (prev_x != 799) begin
            errors++;
            $display("FAIL line_last_x got %0d want 799", prev_x);
        end
        if (d_y !== 10'd1) begin
            errors++;
            $display("FAIL line_next_y got %0d want 1", d_y);
        end
    endtask

    // Shrunken timing: one frame from reset, watching the vertical blanking region.
    task automatic test_vertical();
        int vs_cnt;
        int vs_bad;
        int blank_bad;
        vs_cnt    = 0;
        vs_bad    = 0;
        blank_bad = 0;
        tick(1'b1);
        void'(q_def.pop_front());
        exp_s = q_small.pop_front();
        checks++;
        if (obs_small !== exp_s) begin
            errors++;
            $display("FAIL vert_reset got %s want %s", fmt(obs_small), fmt(exp_s));
        end
        for (int i = 0; i < int'(S_FRAME); i++) begin
            tick(1'b0);
            exp_d = q_def.pop_front();
            exp_s = q_small.pop_front();
            checks += 2;
            if (obs_def !== exp_d) begin
                errors++;
                $display("FAIL vert_def got %s want %s", fmt(obs_def), fmt(exp_d));
            end
            if (obs_small !== exp_s) begin
                errors++;
                $display("FAIL vert_small got %s want %s", fmt(obs_small), fmt(exp_s));
            end
            if (s_vs === 1'b0) begin
                vs_cnt++;
                if (s_y !== 10'd14 && s_y !== 10'd15) vs_bad++;
            end
            if (s_y >= 10'd12 && s_blank !== 1'b0) blank_bad++;
        end
        checks += 3;
        if (vs_cnt != 50) begin
            errors++;
            $display("FAIL vert_vs_width got %0d want 50", vs_cnt);
        end
        if (vs_bad != 0) begin
            errors++;
            $display("FAIL vert_vs_lines got %0d cycles outside lines 14..15 want 0", vs_bad);
        end
        if (blank_bad != 0) begin
            errors++;
            $display("FAIL vert_blank got %0d visible cycles on blank lines want 0", blank_bad);
        end
    endtask

    task automatic test_full_frame();
        int fs_cnt;
        int fs_at;
        logic [1:0] fc_want;
`ifdef VGA_FRAME_CNT_EN
        fc_want = 2'd1;
`else
        fc_want = 2'd0;
`endif
        fs_cnt = 0;
        fs_at  = -1;
        tick(1'b1);
        void'(q_def.pop_front());
        void'(q_small.pop_front());
        for (int i = 1; i <= int'(S_FRAME); i++) begin
            tick(1'b0);
            exp_d = q_def.pop_front();
            exp_s = q_small.pop_front();
            checks += 2;
            if (obs_def !== exp_d) begin
                errors++;
                $display("FAIL frame_def got %s want %s", fmt(obs_def), fmt(exp_d));
            end
            if (obs_small !== exp_s) begin
                errors++;
                $display("FAIL frame_small got %s want %s", fmt(obs_small), fmt(exp_s));
            end
            if (s_fs === 1'b1) begin
                fs_cnt++;
                fs_at = i;
            end
        end
        checks += 3;
        if (s_x !== 10'd0 || s_y !== 10'd0) begin
            errors++;
            $display("FAIL frame_return got x=%0d y=%0d want x=0 y=0", s_x, s_y);
        end
        if (fs_cnt != 1 || fs_at != int'(S_FRAME)) begin
            errors++;
            $display("FAIL frame_start_pulse got %0d pulses last at %0d want 1 at %0d",
                     fs_cnt, fs_at, S_FRAME);
        end
        if (s_fc !== fc_want) begin
            errors++;
            $display("FAIL frame_count_one got %0d want %0d", s_fc, fc_want);
        end
    endtask

    task automatic test_mid_reset();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick(1'b0);
            void'(q_def.pop_front());
            exp_s = q_small.pop_front();
            checks++;
            if (obs_small !== exp_s) begin
                errors++;
                $display("FAIL midrst_run got %s want %s", fmt(obs_small), fmt(exp_s));
            end
            if (s_x === 10'd19 && s_y === 10'd15) found = 1'b1;
        end
        checks += 2;
        if (!found || s_hs !== 1'b0 || s_vs !== 1'b0) begin
            errors++;
            $display("FAIL midrst_setup got found=%b hs=%b vs=%b want found=1 hs=0 vs=0",
                     found, s_hs, s_vs);
        end
        tick(1'b1);
        exp_d = q_def.pop_front();
        void'(q_small.pop_front());
        if (s_x !== 10'd0 || s_y !== 10'd0 || s_hs !== 1'b1 || s_vs !== 1'b1 ||
            s_blank !== 1'b0 || s_fs !== 1'b0 || s_fc !== 2'd0) begin
            errors++;
            $display("FAIL midrst_values got %s want x=0 y=0 hs=1 vs=1 blank=0 fs=0 fc=0",
                     fmt(obs_small));
        end
        checks++;
        if (obs_def !== exp_d) begin
            errors++;
            $display("FAIL midrst_def got %s want %s", fmt(obs_def), fmt(exp_d));
        end
    endtask

    task automatic test_frame_count();
        logic [1:0] seen[$];
        logic [1:0] want[4];
`ifdef VGA_FRAME_CNT_EN
        want = '{2'd1, 2'd2, 2'd3, 2'd0};
`else
        want = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        tick(1'b1);
        void'(q_def.pop_front());
        void'(q_small.pop_front());
        for (int i = 0; i < 4 * int'(S_FRAME); i++) begin
            tick(1'b0);
            void'(q_def.pop_front());
            exp_s = q_small.pop_front();
            checks++;
            if (obs_small !== exp_s) begin
                errors++;
                $display("FAIL fcnt_run got %s want %s", fmt(obs_small), fmt(exp_s));
            end
            if (s_fs === 1'b1) seen.push_back(s_fc);
        end
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL fcnt_pulses got %0d want 4", seen.size());
        end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
                errors++;
                $display("FAIL fcnt_seq[%0d] got %0d want %0d", i, seen[i], want[i]);
            end
        end
    endtask

    initial begin
        m_def   = '0;
        m_small = '0;
        test_reset();
        test_line();
        test_vertical();
        test_full_frame();
        test_mid_reset();
        test_frame_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
